// File: rtl/game_ctrl.sv
// game_ctrl: top-level sequencer for the bird-flying game.
// Owns bird vertical physics, three scrolling tubes with respawn gaps, and the score.
// Optional build macro RANDOM_GAP_EN: when defined, respawn gaps come from a 16-bit
// Galois LFSR; otherwise they cycle through a fixed three-entry table.
module game_ctrl #(
  parameter int unsigned GROUND_Y     = 440,
  parameter int unsigned TUBE_SPACING = 240,
  parameter int unsigned SCROLL       = 2,
  parameter int unsigned BIRD_X       = 160,
  parameter int unsigned FLAP_V       = 8,
  parameter int unsigned GAP_MIN      = 120
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       flap,
  input  logic       over,
  output logic       coll_clr,
  output logic [9:0] tube1_x,
  output logic [9:0] tube2_x,
  output logic [9:0] tube3_x,
  output logic [9:0] tube1_y,
  output logic [9:0] tube2_y,
  output logic [9:0] tube3_y,
  output logic [9:0] bird_y,
  output logic [1:0] state,
  output logic [7:0] score
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPlay  = 2'b01,
    StDying = 2'b10,
    StOver  = 2'b11
  } state_e;

  localparam logic [9:0]        GroundY = 10'(GROUND_Y);
  localparam logic [9:0]        Scroll  = 10'(SCROLL);
  localparam logic [9:0]        WrapAdd = 10'(3 * TUBE_SPACING - SCROLL);
  localparam logic [9:0]        BirdX   = 10'(BIRD_X);
  localparam logic [9:0]        HomeY   = 10'd240;
  localparam logic [9:0]        GapMin  = 10'(GAP_MIN);
  localparam logic signed [5:0] FlapVel = -$signed(6'(FLAP_V));
  localparam logic signed [5:0] VelMax  = 6'sd15;

  function automatic logic [9:0] tube_home_x(input int i);
    return 10'(320 + i * TUBE_SPACING);
  endfunction

  state_e            st_q, st_d;
  logic              flap_q;
  logic              rise;
  logic              coll_clr_q;
  logic [9:0]        bird_q, bird_d;
  logic signed [5:0] vel_q, vel_d;
  logic [9:0]        tube_x_q [3];
  logic [9:0]        tube_x_d [3];
  logic [9:0]        tube_y_q [3];
  logic [9:0]        tube_y_d [3];
  logic [7:0]        score_q, score_d;

  // Physics helpers shared by PLAY and DYING
  logic signed [5:0]  v_eff, v_inc, vel_upd;
  logic signed [10:0] bird_sum;
  logic [9:0]         bird_upd;

  // Tube scroll helpers
  logic [2:0] wrap;
  logic [9:0] gap [3];
  logic [9:0] scroll_x [3];
  logic [7:0] score_upd;

  assign rise = flap & ~flap_q;

`ifdef RANDOM_GAP_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois LFSR, taps 16,14,13,11; free-running in every state
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    for (int i = 0; i < 3; i++) begin
      gap[i] = GapMin + 10'(lfsr_q[6:0]);
    end
  end

  // LFSR state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end
`else
  logic [1:0] gap_idx_q, gap_idx_d, gap_idx_adv;

  // Fixed gaps never go below the configured floor
  function automatic logic [9:0] table_gap(input logic [1:0] idx);
    logic [9:0] g;
    case (idx)
      2'd1:    g = 10'd150;
      2'd2:    g = 10'd330;
      default: g = 10'd240;
    endcase
    return (g < GapMin) ? GapMin : g;
  endfunction

  // Simultaneous wraps take consecutive table entries, tube1 first
  always_comb begin
    gap_idx_adv = gap_idx_q;
    for (int i = 0; i < 3; i++) begin
      gap[i] = table_gap(gap_idx_adv);
      if (wrap[i]) gap_idx_adv = (gap_idx_adv == 2'd2) ? 2'd0 : gap_idx_adv + 2'd1;
    end
  end

  // Gap table index register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) gap_idx_q <= 2'd0;
    else      gap_idx_q <= gap_idx_d;
  end
`endif

  // Bird step: flap overrides velocity; clamp to ceiling (stop) and ground
  always_comb begin
    v_eff    = (st_q == StPlay && rise) ? FlapVel : vel_q;
    v_inc    = (st_q == StPlay && rise) ? FlapVel :
               ((vel_q >= VelMax) ? VelMax : vel_q + 6'sd1);
    bird_sum = $signed({1'b0, bird_q}) + $signed({{5{v_eff[5]}}, v_eff});
    bird_upd = bird_sum[9:0];
    vel_upd  = v_inc;
    if (bird_sum[10]) begin
      bird_upd = 10'd0;
      vel_upd  = 6'sd0;
    end else if (bird_sum[9:0] >= GroundY) begin
      bird_upd = GroundY;
    end
  end

  // Tube scroll with wrap, and score for tubes crossing the bird column
  always_comb begin
    score_upd = score_q;
    for (int i = 0; i < 3; i++) begin
      wrap[i]     = tube_x_q[i] < Scroll;
      scroll_x[i] = wrap[i] ? tube_x_q[i] + WrapAdd : tube_x_q[i] - Scroll;
      if (tube_x_q[i] > BirdX && scroll_x[i] <= BirdX && score_upd != 8'hFF) begin
        score_upd = score_upd + 8'd1;
      end
    end
  end

  // Next-state and datapath selection
  always_comb begin
    st_d     = st_q;
    bird_d   = bird_q;
    vel_d    = vel_q;
    tube_x_d = tube_x_q;
    tube_y_d = tube_y_q;
    score_d  = score_q;
`ifndef RANDOM_GAP_EN
    gap_idx_d = gap_idx_q;
`endif
    unique case (st_q)
      StIdle: begin
        if (rise) begin
          st_d    = StPlay;
          score_d = 8'd0;
          vel_d   = FlapVel;
        end
      end
      StPlay: begin
        // Collision wins over a same-cycle frame tick: no update that frame
        if (over || bird_q == GroundY) begin
          st_d = StDying;
        end else if (frame_tick) begin
          bird_d  = bird_upd;
          vel_d   = vel_upd;
          score_d = score_upd;
          for (int i = 0; i < 3; i++) begin
            tube_x_d[i] = scroll_x[i];
            if (wrap[i]) tube_y_d[i] = gap[i];
          end
`ifndef RANDOM_GAP_EN
          gap_idx_d = gap_idx_adv;
`endif
        end
      end
      StDying: begin
        if (bird_q == GroundY) begin
          st_d = StOver;
        end else if (frame_tick) begin
          bird_d = bird_upd;
          vel_d  = vel_upd;
        end
      end
      StOver: begin
        if (rise) begin
          st_d   = StIdle;
          bird_d = HomeY;
          vel_d  = 6'sd0;
          for (int i = 0; i < 3; i++) begin
            tube_x_d[i] = tube_home_x(i);
            tube_y_d[i] = HomeY;
          end
        end
      end
    endcase
  end

  // State registers; clr wipes everything at once
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st_q       <= StIdle;
      flap_q     <= 1'b0;
      coll_clr_q <= 1'b1;
      bird_q     <= HomeY;
      vel_q      <= 6'sd0;
      score_q    <= 8'd0;
      for (int i = 0; i < 3; i++) begin
        tube_x_q[i] <= tube_home_x(i);
        tube_y_q[i] <= HomeY;
      end
    end else begin
      st_q       <= st_d;
      flap_q     <= flap;
      coll_clr_q <= (st_d == StIdle);
      bird_q     <= bird_d;
      vel_q      <= vel_d;
      score_q    <= score_d;
      tube_x_q   <= tube_x_d;
      tube_y_q   <= tube_y_d;
    end
  end

  assign coll_clr = coll_clr_q;
  assign state    = st_q;
  assign bird_y   = bird_q;
  assign score    = score_q;
  assign tube1_x  = tube_x_q[0];
  assign tube2_x  = tube_x_q[1];
  assign tube3_x  = tube_x_q[2];
  assign tube1_y  = tube_y_q[0];
  assign tube2_y  = tube_y_q[1];
  assign tube3_y  = tube_y_q[2];

endmodule
